ps2_keyboard_rx: RTL and testbench
==================================

# ps2_keyboard_rx

Parametrised PS/2 keyboard receiver. It deserialises scan-code frames with full start, parity and stop checking, and buffers raw bytes in a FIFO of configurable depth. It also keeps a held-key bitmap for a configurable table of set-2 keys, including E0-extended codes and correct F0 break handling. It sits between the board PS/2 pins and the game/input logic, which reads bytes through the `rdn` pop handshake or polls `key_down` directly.

## Interface
- `FIFO_AW`, default 3: FIFO depth is 2^FIFO_AW bytes.
- `NUM_KEYS`, default 8: number of tracked keys.
- `KEY_TABLE`, default W, A, S, D, Up, Left, Down, Right: `NUM_KEYS*9`-bit packed list. Each entry is {ext, code[7:0]}; entry i lives at bits [9i+8:9i]. Default codes are {0,1D} W, {0,1C} A, {0,1B} S, {0,23} D, {1,75} Up, {1,6B} Left, {1,72} Down, {1,74} Right.
- `TIMEOUT`, default 50000: idle `clk` cycles allowed mid-frame before the bit counter is abandoned.

Ports:
- `clk`  in  1  system clock.
- `clrn`  in  1  reset, asynchronous and active-low.
- `ps2_clk`, `ps2_data`  in  1  raw PS/2 pins, asynchronous to `clk`.
- `rdn`  in  1  active-low pop request.
- `data`  out  8  byte at the FIFO head. Combinational; valid while `ready` is high.
- `ready`  out  1  FIFO not empty.
- `overflow`  out  1  sticky; a byte was dropped because the FIFO was full.
- `level`  out  FIFO_AW+1  FIFO occupancy.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.
- `key_down`  out  NUM_KEYS  bit i = key i is currently held.

## Operation
- **Clock-edge detection:** `ps2_clk` passes through a 3-flop synchroniser. `sample` is high for one `clk` cycle on each detected falling edge. `ps2_data` is taken from a matching 2-flop synchroniser.
- **Frame format:** 11 bits in this order: start bit (0), 8 data bits LSB first, odd parity, stop bit (1). A bit counter runs 0..10.
- **Frame acceptance:** on the stop-bit sample the frame is accepted only if start == 0, the XOR of the data bits and parity == 1, and stop == 1.
  - Otherwise `frame_err` pulses and nothing is written.
  - The counter returns to 0 in either case.
- **Timeout:** a counter is cleared on every `sample`. If the bit counter is non-zero and the timeout counter reaches `TIMEOUT`, the bit counter resets to 0 and `frame_err` pulses.
- **FIFO:** power-of-two circular buffer with wrapping pointers and an explicit count.
  - Push on an accepted byte when not full.
  - Pop when `rdn == 0 && ready`.
  - Push to a full FIFO drops the byte and sets `overflow`.
  - Simultaneous push and pop on a full FIFO: both happen, no overflow.
  - `overflow` clears on the next successful pop.
- **Decoder FSM**, running on every accepted byte whether or not the FIFO pushed it. States are `IDLE`, `EXT`, `BRK`, `EXT_BRK`.
  - `IDLE`: E0 goes to `EXT`; F0 goes to `BRK`; any other byte is a make code with ext=0.
  - `EXT`: F0 goes to `EXT_BRK`; any other byte is a make code with ext=1, then back to `IDLE`.
  - `BRK`: the byte is a break code with ext=0, then back to `IDLE`.
  - `EXT_BRK`: the byte is a break code with ext=1, then back to `IDLE`.
  - E1 (Pause prefix), AA (BAT) and FA (ack) in any state return to `IDLE` with no key change.
- **Key table lookup:** a make code matching entry {ext,code} sets `key_down[i]`; a break code clears it. All matching entries update. Typematic repeats of a make code are idempotent.

## Timing
- Let T be the `clk` edge at which the stop-bit `sample` is high. At T+1:
  - the FIFO write is visible (`ready`, `level`, `data` if the FIFO was empty);
  - `key_down` and the FSM state are updated;
  - `frame_err` pulses for the single cycle T+1 when applicable.
- Pin-to-`sample` latency is 3 `clk` cycles.
- Pop takes effect at the edge where `rdn == 0 && ready`. `data` shows the next byte in the following cycle. Holding `rdn` low pops one byte per cycle.
- **Reset (asynchronous, any time, including mid-frame):**
  - bit counter, timeout counter, pointers and `level` go to 0;
  - FSM goes to `IDLE`;
  - `ready`, `overflow`, `frame_err` and `key_down` go to 0;
  - FIFO RAM contents are not cleared.

## Structure
- **Package `ps2_pkg`:** scan-code constants `PS2_EXT` = E0, `PS2_BRK` = F0, `PS2_PAUSE` = E1, `PS2_BAT` = AA, `PS2_ACK` = FA; the decoder state enum; the default key-table constant.
- **Sub-module `ps2_frame_rx`:** synchronisers, edge detect, deserialiser, checks and timeout. Its outputs are `byte_valid`, `byte[7:0]` and `frame_err`.
- FIFO and decoder stay in the top module.

## Test plan
- **W press and release:** frames 1D (parity 1), then F0 (parity 1), then 1D. Required: `key_down[0]` rises at T+1 of the first frame and falls at T+1 of the third; the FIFO holds 1D, F0, 1D; `level` = 3.
- **Extended Up:** frames E0 (parity 0), 75 (parity 0), E0, F0, 75. Required: `key_down[4]` is 1 after byte 2 and 0 after byte 5; `key_down[0..3]` never change.
- **Bad parity:** frame 1D with parity 0. Required: one `frame_err` pulse; `level` unchanged; `key_down` unchanged.
- **Overflow at default depth 8:** push 9 bytes without popping. Required: `level` = 8; `overflow` = 1; pop returns bytes 1..8 in order; `overflow` = 0 after the first pop.
- **Timeout recovery:** send 5 bits, stall for `TIMEOUT`+10 cycles, then send a clean 1C frame. Required: `frame_err` pulses once; 1C is accepted; `key_down[1]` = 1.
- **Mid-frame reset:** assert `clrn` low during bit 6 while `key_down` = 0x01. Required: all outputs are 0 immediately; the next full frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decoder state type and default key table for the PS/2 receiver.
`timescale 1ns/1ps
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ACK   = 8'hFA;

    localparam int unsigned KEY_ENTRY_W = 9;

    // One key-table entry: extended-prefix flag plus set-2 code.
    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_e;

    // Entry 0 sits in the LSBs: W, A, S, D, Up, Left, Down, Right.
    localparam logic [8*KEY_ENTRY_W-1:0] PS2_DEFAULT_KEYS = {
        9'h174, 9'h172, 9'h16B, 9'h175,
        9'h023, 9'h01B, 9'h01C, 9'h01D
    };

    // Bytes that abandon any prefix sequence without touching key state.
    function automatic logic is_flush_code(input logic [7:0] b);
        return (b == PS2_PAUSE) || (b == PS2_BAT) || (b == PS2_ACK);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: pin synchronisers, falling-edge detect, 11-bit frame checks and mid-frame timeout.
`timescale 1ns/1ps
module ps2_frame_rx #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [3:0]  STOP_IDX = 4'd10;

    logic [2:0]       clk_sync_q;
    logic [1:0]       dat_sync_q;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             frame_err_q, frame_err_d;
    logic             sample;
    logic             rx_bit;
    logic             stop_hit;
    logic             frame_ok;
    logic             timeout_hit;

    // Synchronise the asynchronous pins; idle-high reset avoids a false edge after reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    assign sample      = clk_sync_q[2] & ~clk_sync_q[1];
    assign rx_bit      = dat_sync_q[1];
    assign stop_hit    = sample && (bit_cnt_q == STOP_IDX);
    // shift_q holds start at [0], data at [8:1], parity at [9]; the stop bit is the live sample.
    assign frame_ok    = !shift_q[0] && (^shift_q[9:1]) && rx_bit;
    assign timeout_hit = !sample && (bit_cnt_q != 4'd0) && (tmo_cnt_q == TMO_W'(TIMEOUT));

    // Accepted byte is presented in the stop-bit sample cycle so the top commits it on the same edge.
    assign byte_valid = stop_hit && frame_ok;
    assign byte_data  = shift_q[8:1];
    assign frame_err  = frame_err_q;

    // Bit counting, shifting, frame checking and idle timeout.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tmo_cnt_d   = tmo_cnt_q;
        frame_err_d = 1'b0;
        if (sample) begin
            tmo_cnt_d = '0;
            if (stop_hit) begin
                bit_cnt_d   = '0;
                frame_err_d = !frame_ok;
            end else begin
                shift_d   = {rx_bit, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q == 4'd0) begin
            tmo_cnt_d = '0;
        end else if (timeout_hit) begin
            bit_cnt_d   = '0;
            tmo_cnt_d   = '0;
            frame_err_d = 1'b1;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    // Deserialiser state registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tmo_cnt_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_cnt_q   <= tmo_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: byte FIFO with pop handshake plus set-2 make/break decoder driving a held-key bitmap.
`timescale 1ns/1ps
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned                  FIFO_AW   = 3,
    parameter int unsigned                  NUM_KEYS  = 8,
    parameter logic [NUM_KEYS*9-1:0]        KEY_TABLE = PS2_DEFAULT_KEYS,
    parameter int unsigned                  TIMEOUT   = 50000
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    input  logic                rdn,
    output logic [7:0]          data,
    output logic                ready,
    output logic                overflow,
    output logic [FIFO_AW:0]    level,
    output logic                frame_err,
    output logic [NUM_KEYS-1:0] key_down
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;

    logic             rx_valid;
    logic [7:0]       rx_byte;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q, ready_d;
    logic               overflow_q, overflow_d;
    logic               push, pop, full, drop;

    dec_state_e          state_q, state_d;
    logic [NUM_KEYS-1:0] key_q, key_d;
    logic                key_evt;
    logic                key_make;
    key_entry_t          rx_key;

    ps2_frame_rx #(
        .TIMEOUT (TIMEOUT)
    ) u_frame_rx (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (rx_valid),
        .byte_data  (rx_byte),
        .frame_err  (frame_err)
    );

    // FIFO control: a pop frees the slot an accepted byte needs when full.
    always_comb begin
        pop        = !rdn && ready_q;
        full       = (count_q == CNT_W'(DEPTH));
        push       = rx_valid && (!full || pop);
        drop       = rx_valid && full && !pop;
        wr_ptr_d   = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        ready_d    = (count_d != '0);
        overflow_d = pop ? 1'b0 : (drop ? 1'b1 : overflow_q);
    end

    // FIFO pointers, occupancy and status.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_byte;
        end
    end

    // Decoder next state: classify each accepted byte as prefix, make or break.
    always_comb begin
        state_d     = state_q;
        key_evt     = 1'b0;
        key_make    = 1'b0;
        rx_key.ext  = 1'b0;
        rx_key.code = rx_byte;
        if (rx_valid) begin
            if (is_flush_code(rx_byte)) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rx_byte == PS2_EXT) begin
                            state_d = EXT;
                        end else if (rx_byte == PS2_BRK) begin
                            state_d = BRK;
                        end else begin
                            key_evt  = 1'b1;
                            key_make = 1'b1;
                        end
                    end
                    EXT: begin
                        if (rx_byte == PS2_BRK) begin
                            state_d = EXT_BRK;
                        end else begin
                            key_evt    = 1'b1;
                            key_make   = 1'b1;
                            rx_key.ext = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                    BRK: begin
                        key_evt = 1'b1;
                        state_d = IDLE;
                    end
                    EXT_BRK: begin
                        key_evt    = 1'b1;
                        rx_key.ext = 1'b1;
                        state_d    = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Key table lookup: every matching entry follows the make/break event.
    always_comb begin
        key_d = key_q;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (key_evt && (key_entry_t'(KEY_TABLE[9*i +: 9]) == rx_key)) begin
                key_d[i] = key_make;
            end
        end
    end

    // Decoder state and held-key bitmap registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    assign data     = mem_q[rd_ptr_q];
    assign ready    = ready_q;
    assign overflow = overflow_q;
    assign level    = count_q;
    assign key_down = key_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: PS/2 host-side driver, queue model of the FIFO and a table-based key model.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

    localparam int unsigned TB_TIMEOUT = 400;
    localparam int unsigned HALF_NS    = 200;
    localparam int unsigned DEPTH      = 8;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rdn;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic [3:0] level;
    logic       frame_err;
    logic [7:0] key_down;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf;
    logic [7:0] exp_keys;
    bit         pend_ext;
    bit         pend_brk;
    int         err_expected = 0;
    int         err_seen     = 0;
    logic [8:0] key_tbl [8];

    ps2_keyboard_rx #(
        .FIFO_AW  (3),
        .NUM_KEYS (8),
        .TIMEOUT  (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rdn       (rdn),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .level     (level),
        .frame_err (frame_err),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_key(input logic ext, input logic [7:0] code, input logic make);
        for (int i = 0; i < 8; i++) begin
            if (key_tbl[i] == {ext, code}) exp_keys[i] = make;
        end
    endtask

    // Reference behaviour for one accepted byte: queue it (or note the drop) and apply scan-code rules.
    task automatic model_byte(input logic [7:0] b);
        if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
        else exp_q.push_back(b);
        if (b == 8'hE1 || b == 8'hAA || b == 8'hFA) begin
            pend_ext = 0; pend_brk = 0;
        end else if (pend_brk) begin
            model_key(pend_ext, b, 1'b0);
            pend_ext = 0; pend_brk = 0;
        end else if (pend_ext) begin
            if (b == 8'hF0) pend_brk = 1;
            else begin
                model_key(1'b1, b, 1'b1);
                pend_ext = 0;
            end
        end else if (b == 8'hE0) begin
            pend_ext = 1;
        end else if (b == 8'hF0) begin
            pend_brk = 1;
        end else begin
            model_key(1'b0, b, 1'b1);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_keys = '0;
        pend_ext = 0;
        pend_brk = 0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rdn(input logic v);
        @(posedge clk);
        #1;
        rdn = v;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        #(HALF_NS);
        ps2_clk = 1'b0;
        #(HALF_NS);
        ps2_clk = 1'b1;
    endtask

    // Host-side frame; expectations are registered at the stop-bit falling edge, before the DUT sees it.
    task automatic send_frame(input logic [7:0] b, input bit bad_par = 0,
                              input bit bad_start = 0, input bit bad_stop = 0);
        logic [10:0] bits;
        bits[0]   = bad_start;
        bits[8:1] = b;
        bits[9]   = (~^b) ^ bad_par;
        bits[10]  = ~bad_stop;
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        ps2_data = bits[10];
        #(HALF_NS);
        ps2_clk = 1'b0;
        if (bad_par || bad_start || bad_stop) err_expected++;
        else model_byte(b);
        #(HALF_NS);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        #(2 * HALF_NS);
        check("key_down_model", key_down, exp_keys);
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        logic [8:0] e;
        r = $urandom_range(0, 9);
        e = key_tbl[$urandom_range(0, 7)];
        case (r)
            0, 1, 2, 3: return e[7:0];
            4:          return 8'hE0;
            5:          return 8'hF0;
            6:          return ($urandom_range(0, 1) == 0) ? 8'hFA : 8'hAA;
            default:    return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Monitor: compare every popped byte and account for every frame_err pulse.
    always @(negedge clk) begin
        if (clrn === 1'b1) begin
            if (ready && !rdn) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected_ready", ready, 1'b0);
                end else begin
                    check("pop_data", data, exp_q.pop_front());
                    exp_ovf = 1'b0;
                end
            end
            if (frame_err) begin
                err_seen++;
                check("frame_err_expected", 32'(err_seen <= err_expected), 1);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at t=%0t checks=%0d", $time, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        key_tbl[0] = 9'h01D; key_tbl[1] = 9'h01C; key_tbl[2] = 9'h01B; key_tbl[3] = 9'h023;
        key_tbl[4] = 9'h175; key_tbl[5] = 9'h16B; key_tbl[6] = 9'h172; key_tbl[7] = 9'h174;
        reset_model();
        clrn     = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rdn      = 1'b1;
        wait_clks(4);
        check("reset_ready", ready, 0);
        check("reset_level", level, 0);
        check("reset_overflow", overflow, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_key_down", key_down, 0);
        @(negedge clk);
        clrn = 1'b1;
        wait_clks(4);

        // W press and release, held in the FIFO.
        send_frame(8'h1D);
        check("w_make_key0", key_down[0], 1);
        send_frame(8'hF0);
        send_frame(8'h1D);
        check("w_break_key0", key_down[0], 0);
        check("w_level", level, 3);
        set_rdn(1'b0);
        wait_clks(10);
        check("w_drained_level", level, 0);

        // Extended Up press and release.
        send_frame(8'hE0);
        send_frame(8'h75);
        check("up_make_key4", key_down[4], 1);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        check("up_break_key4", key_down[4], 0);
        check("up_other_keys", key_down[3:0], 0);

        // Bad parity is rejected without side effects.
        set_rdn(1'b1);
        send_frame(8'h1D, 1);
        check("badpar_level", level, exp_q.size());
        check("badpar_err_count", err_seen, err_expected);

        // Overflow at depth 8.
        for (int i = 0; i < 9; i++) send_frame(8'($urandom_range(0, 255)));
        check("ovf_level", level, 8);
        check("ovf_flag", overflow, 1);
        set_rdn(1'b0);
        set_rdn(1'b1);
        wait_clks(1);
        check("ovf_cleared_after_pop", overflow, exp_ovf);
        check("ovf_level_after_pop", level, 7);
        set_rdn(1'b0);
        wait_clks(15);
        check("ovf_drained_level", level, 0);

        // Timeout recovery after a partial frame.
        send_frame(8'hFA);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        err_expected++;
        wait_clks(TB_TIMEOUT + 10);
        check("timeout_err_count", err_seen, err_expected);
        send_frame(8'h1C);
        check("timeout_key1", key_down[1], 1);

        // Mid-frame reset with only W held.
        send_frame(8'hF0);
        send_frame(8'h1C);
        send_frame(8'h1D);
        check("prereset_keys", key_down, 8'h01);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        #(HALF_NS / 2);
        clrn = 1'b0;
        #1;
        reset_model();
        check("midreset_ready", ready, 0);
        check("midreset_level", level, 0);
        check("midreset_overflow", overflow, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_key_down", key_down, 0);
        wait_clks(3);
        @(negedge clk);
        clrn = 1'b1;
        wait_clks(3);
        send_frame(8'h23);
        check("postreset_key3", key_down, 8'h08);

        // Randomized traffic with occasional corrupted frames.
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            send_frame(pick_byte(), kind == 0, kind == 1, kind == 2);
        end

        wait_clks(20);
        check("final_level", level, 0);
        check("final_frame_err_count", err_seen, err_expected);
        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
